addsub_pipe: RTL and testbench

//  Parametrised pipelined adder/subtractor with per-transaction op select and valid/ready flow control.

---
 rtl/addsub_pkg.sv | 63 ++++++
 rtl/addsub_stage.sv | 40 ++++
 rtl/addsub_pipe.sv | 105 ++++++++++
 tb/tb_addsub_pipe.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and arithmetic helpers for the pipelined add/sub unit.
// Functions work on a MAX_W-wide word and take the active width as an argument,
// so one definition serves every WIDTH below MAX_W.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the helpers can handle; WIDTH must stay below this.
  localparam int MAX_W = 256;

  typedef logic [MAX_W-1:0] word_t;

  // Ones in the low 'width' bits.
  function automatic word_t width_mask(input int width);
    return {MAX_W{1'b1}} >> (MAX_W - width);
  endfunction

  // Largest positive two's-complement value of 'width' bits.
  function automatic word_t smax(input int width);
    return width_mask(width) >> 1;
  endfunction

  // Most negative two's-complement value of 'width' bits (sign bit only).
  function automatic word_t smin(input int width);
    return width_mask(width) ^ smax(width);
  endfunction

  // Returns {ovf, s}. Sub is done as a + ~b + 1 on a width+1 bit sum.
  // Bit positions are picked with masks rather than variable indices.
  function automatic logic [MAX_W:0] addsub_calc(input word_t a, input word_t b,
                                                 input logic op, input logic signed_mode,
                                                 input int width);
    word_t          mask;
    word_t          sign_bit;
    word_t          am;
    word_t          bx;
    logic [MAX_W:0] sum;
    logic [MAX_W:0] carry_bit;
    logic           sa;
    logic           sb;
    logic           ss;
    logic           cy;
    logic           ovf;
    mask      = width_mask(width);
    sign_bit  = smin(width);
    am        = a & mask;
    bx        = (op == OP_ADD) ? (b & mask) : (~b & mask);
    sum       = {1'b0, am} + {1'b0, bx} + {{MAX_W{1'b0}}, op};
    carry_bit = {1'b0, mask} + {{MAX_W{1'b0}}, 1'b1};
    sa        = |(am & sign_bit);
    sb        = |(bx & sign_bit);
    ss        = |(sum[MAX_W-1:0] & sign_bit);
    cy        = |(sum & carry_bit);
    if (signed_mode) begin
      ovf = (sa == sb) && (ss != sa);
    end else begin
      ovf = (op == OP_SUB) ? ~cy : cy;
    end
    return {ovf, sum[MAX_W-1:0] & mask};
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline register holding {valid, s, ovf, tag}.
// Latency 1 cycle; loads only when shift=1.
// Backpressure: holds everything while shift=0; payload moves only with a valid entry.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_s,
  input  logic             src_ovf,
  input  logic [TAG_W-1:0] src_tag,
  output logic             valid,
  output logic [WIDTH-1:0] s,
  output logic             ovf,
  output logic [TAG_W-1:0] tag
);

  // Take the upstream entry on shift; invalid entries leave stale payload behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      s     <= '0;
      ovf   <= 1'b0;
      tag   <= '0;
    end else if (shift) begin
      valid <= src_valid;
      if (src_valid) begin
        s   <= src_s;
        ovf <= src_ovf;
        tag <= src_tag;
      end
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub with op select, overflow flag and sideband tag; ADDSUB_PIPE_SAT_EN enables clamping.
// Latency LATENCY cycles from accept to out_valid, one op per cycle.
// Backpressure: whole pipe stalls when the output holds a result that is not taken; bubbles are not collapsed.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 6,
  parameter int SIGNED  = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  // The pipe moves when the output slot is empty or being drained.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic [MAX_W:0]   calc;
  logic [WIDTH-1:0] calc_s;
  logic             calc_ovf;
  logic [WIDTH-1:0] load_s;

  assign calc     = addsub_calc(word_t'(in_a), word_t'(in_b), in_op, SIGNED != 0, WIDTH);
  assign calc_ovf = calc[MAX_W];
  assign calc_s   = WIDTH'(calc[MAX_W-1:0]);

`ifdef ADDSUB_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(smin(WIDTH));

  // Clamp on overflow; signed direction follows the sign of A, which matches B's effective sign.
  always_comb begin
    load_s = calc_s;
    if (calc_ovf) begin
      if (SIGNED != 0) begin
        load_s = in_a[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end else begin
        load_s = (in_op == OP_SUB) ? '0 : '1;
      end
    end
  end
`else
  // Wrapped result goes straight into stage 0.
  always_comb begin
    load_s = calc_s;
  end
`endif

  logic             stg_valid [LATENCY];
  logic [WIDTH-1:0] stg_s     [LATENCY];
  logic             stg_ovf   [LATENCY];
  logic [TAG_W-1:0] stg_tag   [LATENCY];

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_first
      addsub_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift     (adv),
        .src_valid (in_valid),
        .src_s     (load_s),
        .src_ovf   (calc_ovf),
        .src_tag   (in_tag),
        .valid     (stg_valid[i]),
        .s         (stg_s[i]),
        .ovf       (stg_ovf[i]),
        .tag       (stg_tag[i])
      );
    end else begin : g_next
      addsub_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift     (adv),
        .src_valid (stg_valid[i-1]),
        .src_s     (stg_s[i-1]),
        .src_ovf   (stg_ovf[i-1]),
        .src_tag   (stg_tag[i-1]),
        .valid     (stg_valid[i]),
        .s         (stg_s[i]),
        .ovf       (stg_ovf[i]),
        .tag       (stg_tag[i])
      );
    end
  end

  assign out_valid = stg_valid[LATENCY-1];
  assign out_s     = stg_s[LATENCY-1];
  assign out_ovf   = stg_ovf[LATENCY-1];
  assign out_tag   = stg_tag[LATENCY-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: signed 64-bit main instance, unsigned 64-bit instance, 8-bit LATENCY=1 instance.
// Expected results come from an integer-range reference model and a FIFO scoreboard.
module tb_addsub_pipe;
  import addsub_pkg::*;

`ifdef ADDSUB_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic signed [66:0] SMAX67 = 67'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [66:0] SMIN67 = -67'sh0_8000_0000_0000_0000;
  localparam logic signed [66:0] UMAX67 = 67'sh0_FFFF_FFFF_FFFF_FFFF;

  int total = 0;
  int bad   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main: signed, 64-bit, latency 6
  logic        m_in_valid, m_in_ready, m_in_op, m_out_valid, m_out_ready, m_out_ovf;
  logic [63:0] m_in_a, m_in_b, m_out_s;
  logic [3:0]  m_in_tag, m_out_tag;
  // unsigned, 64-bit, latency 6
  logic        u_in_valid, u_in_ready, u_in_op, u_out_valid, u_out_ready, u_out_ovf;
  logic [63:0] u_in_a, u_in_b, u_out_s;
  logic [3:0]  u_in_tag, u_out_tag;
  // signed, 8-bit, latency 1
  logic        l_in_valid, l_in_ready, l_in_op, l_out_valid, l_out_ready, l_out_ovf;
  logic [7:0]  l_in_a, l_in_b, l_out_s;
  logic [3:0]  l_in_tag, l_out_tag;

  addsub_pipe #(.WIDTH(64), .LATENCY(6), .SIGNED(1), .TAG_W(4)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_op(m_in_op),
    .in_a(m_in_a), .in_b(m_in_b), .in_tag(m_in_tag), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_s(m_out_s), .out_ovf(m_out_ovf), .out_tag(m_out_tag));

  addsub_pipe #(.WIDTH(64), .LATENCY(6), .SIGNED(0), .TAG_W(4)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready), .in_op(u_in_op),
    .in_a(u_in_a), .in_b(u_in_b), .in_tag(u_in_tag), .out_valid(u_out_valid),
    .out_ready(u_out_ready), .out_s(u_out_s), .out_ovf(u_out_ovf), .out_tag(u_out_tag));

  addsub_pipe #(.WIDTH(8), .LATENCY(1), .SIGNED(1), .TAG_W(4)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_op(l_in_op),
    .in_a(l_in_a), .in_b(l_in_b), .in_tag(l_in_tag), .out_valid(l_out_valid),
    .out_ready(l_out_ready), .out_s(l_out_s), .out_ovf(l_out_ovf), .out_tag(l_out_tag));

  typedef struct packed {
    logic [63:0] s;
    logic        ovf;
    logic [3:0]  tag;
  } res_t;

  res_t exp_q[$];

  // True mathematical result, then range check against the representable interval.
  function automatic res_t ref_model(input logic [63:0] a, input logic [63:0] b, input logic op,
                                     input logic sgn, input logic [3:0] tag);
    logic signed [66:0] ta, tb, t;
    res_t r;
    ta = sgn ? {{3{a[63]}}, a} : {3'b000, a};
    tb = sgn ? {{3{b[63]}}, b} : {3'b000, b};
    t  = (op == OP_SUB) ? (ta - tb) : (ta + tb);
    r.tag = tag;
    r.s   = t[63:0];
    if (sgn) r.ovf = (t > SMAX67) || (t < SMIN67);
    else     r.ovf = (t < 0) || (t > UMAX67);
    if (SAT && r.ovf) begin
      if (sgn) r.s = (t > 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
      else     r.s = (t < 0) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h0;
      4:       return 64'h1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the idle main instance and wait (bounded) for its result.
  task automatic run_one_main(input logic [63:0] a, input logic [63:0] b, input logic op,
                              input logic [3:0] tag, output res_t got, output int lat);
    m_in_a = a; m_in_b = b; m_in_op = op; m_in_tag = tag;
    m_in_valid = 1'b1; m_out_ready = 1'b1;
    tick();
    m_in_valid = 1'b0;
    lat = 0;
    got = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m_out_valid) begin
        got = {m_out_s, m_out_ovf, m_out_tag};
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({m_out_valid, m_out_s, m_out_ovf, m_out_tag} !== 70'h0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b s=%h ovf=%b tag=%h want all zero",
               m_out_valid, m_out_s, m_out_ovf, m_out_tag);
    end
    total++;
    if (m_in_ready !== 1'b1 || u_out_valid !== 1'b0 || l_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got in_ready=%b u_valid=%b l_valid=%b want 1 0 0",
               m_in_ready, u_out_valid, l_out_valid);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_signed_ops();
    res_t got, want;
    int   lat;
    run_one_main(64'd5, 64'd7, OP_SUB, 4'd3, got, lat);
    total++;
    if (lat !== 6) begin
      bad++;
      $display("FAIL sub_latency got %0d want 6", lat);
    end
    want = {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'd3};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL sub_5_7 got %h want %h", got, want);
    end
    tick();
    run_one_main(64'h8000_0000_0000_0000, 64'd1, OP_SUB, 4'd9, got, lat);
    want = {SAT ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'd9};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL sub_min_ovf got %h want %h", got, want);
    end
    tick();
    run_one_main(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 4'd4, got, lat);
    want = {SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000, 1'b1, 4'd4};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL add_max_ovf got %h want %h", got, want);
    end
    tick();
  endtask

  task automatic test_unsigned();
    res_t want [3];
    want[0] = {SAT ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0, 1'b1, 4'd1};
    want[1] = {SAT ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'd2};
    want[2] = {64'd3, 1'b0, 4'd3};
    u_out_ready = 1'b1;
    u_in_valid = 1'b1; u_in_op = OP_ADD; u_in_a = 64'hFFFF_FFFF_FFFF_FFFF; u_in_b = 64'd1; u_in_tag = 4'd1;
    tick();
    u_in_op = OP_SUB; u_in_a = 64'd3; u_in_b = 64'd5; u_in_tag = 4'd2;
    tick();
    u_in_op = OP_ADD; u_in_a = 64'd1; u_in_b = 64'd2; u_in_tag = 4'd3;
    tick();
    u_in_valid = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (u_out_valid !== 1'b1 || {u_out_s, u_out_ovf, u_out_tag} !== want[i]) begin
        bad++;
        $display("FAIL unsigned_%0d got valid=%b %h want valid=1 %h",
                 i, u_out_valid, {u_out_s, u_out_ovf, u_out_tag}, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_latency1();
    l_out_ready = 1'b1;
    l_in_valid = 1'b1; l_in_op = OP_ADD; l_in_a = 8'h7F; l_in_b = 8'h01; l_in_tag = 4'd5;
    tick();
    l_in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (l_out_valid !== 1'b1 || l_out_s !== (SAT ? 8'h7F : 8'h80) || l_out_ovf !== 1'b1 || l_out_tag !== 4'd5) begin
      bad++;
      $display("FAIL lat1_add got valid=%b s=%h ovf=%b tag=%h want 1 %h 1 5",
               l_out_valid, l_out_s, l_out_ovf, l_out_tag, SAT ? 8'h7F : 8'h80);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   issued = 0, popped = 0, first_pop = -1, last_pop = -1, pushed_b = 0, popped_b = 0;
    res_t e, snap;
    bit   have_snap = 1'b0;
    exp_q.delete();
    m_out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && popped < 20; cyc++) begin
      m_in_valid = (issued < 20);
      m_in_a = rand_operand(); m_in_b = rand_operand(); m_in_op = 1'($urandom_range(0, 1));
      m_in_tag = 4'(issued % 16);
      @(negedge clk);
      if (m_out_valid && m_out_ready) begin
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        if ({m_out_s, m_out_ovf, m_out_tag} !== e) begin
          bad++;
          $display("FAIL b2b_data got %h want %h", {m_out_s, m_out_ovf, m_out_tag}, e);
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        popped++;
      end
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(ref_model(m_in_a, m_in_b, m_in_op, 1'b1, m_in_tag));
        issued++;
      end
      tick();
    end
    m_in_valid = 1'b0;
    total++;
    if (popped !== 20 || last_pop - first_pop !== 19) begin
      bad++;
      $display("FAIL b2b_stream got %0d results over %0d cycles want 20 over 20",
               popped, last_pop - first_pop + 1);
    end
    // Stall: keep offering ops with the consumer blocked.
    m_out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      m_in_valid = 1'b1;
      m_in_a = rand_operand(); m_in_b = rand_operand(); m_in_op = 1'($urandom_range(0, 1));
      m_in_tag = 4'(cyc);
      @(negedge clk);
      if (m_out_valid) begin
        total++;
        if (m_in_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_in_ready got %b want 0", m_in_ready);
        end
        if (have_snap) begin
          total++;
          if ({m_out_s, m_out_ovf, m_out_tag} !== snap) begin
            bad++;
            $display("FAIL stall_hold got %h want %h", {m_out_s, m_out_ovf, m_out_tag}, snap);
          end
        end
        snap = {m_out_s, m_out_ovf, m_out_tag};
        have_snap = 1'b1;
      end
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(ref_model(m_in_a, m_in_b, m_in_op, 1'b1, m_in_tag));
        pushed_b++;
      end
      tick();
    end
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (m_out_valid) begin
        total++;
        e = exp_q.pop_front();
        if ({m_out_s, m_out_ovf, m_out_tag} !== e) begin
          bad++;
          $display("FAIL stall_drain got %h want %h", {m_out_s, m_out_ovf, m_out_tag}, e);
        end
        popped_b++;
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (popped_b !== pushed_b || pushed_b == 0 || m_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_count got popped=%0d valid=%b want popped=%0d (nonzero) valid=0",
               popped_b, m_out_valid, pushed_b);
    end
    tick();
  endtask

  task automatic test_random();
    int   issued = 0, popped = 0;
    res_t e, prev;
    bit   prev_hold = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 8000 && (issued < 1000 || popped < 1000); cyc++) begin
      m_in_valid  = (issued < 1000) && ($urandom_range(0, 9) < 7);
      m_in_a      = rand_operand();
      m_in_b      = rand_operand();
      m_in_op     = 1'($urandom_range(0, 1));
      m_in_tag    = 4'($urandom_range(0, 15));
      m_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_hold) begin
        total++;
        if (m_out_valid !== 1'b1 || {m_out_s, m_out_ovf, m_out_tag} !== prev) begin
          bad++;
          $display("FAIL rand_hold got valid=%b %h want valid=1 %h",
                   m_out_valid, {m_out_s, m_out_ovf, m_out_tag}, prev);
        end
      end
      prev_hold = m_out_valid && !m_out_ready;
      prev = {m_out_s, m_out_ovf, m_out_tag};
      if (m_out_valid && m_out_ready) begin
        total++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        if ({m_out_s, m_out_ovf, m_out_tag} !== e) begin
          bad++;
          $display("FAIL rand_data #%0d got %h want %h", popped, {m_out_s, m_out_ovf, m_out_tag}, e);
        end
        popped++;
      end
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(ref_model(m_in_a, m_in_b, m_in_op, 1'b1, m_in_tag));
        issued++;
      end
      tick();
    end
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    total++;
    if (popped !== 1000 || issued !== 1000) begin
      bad++;
      $display("FAIL rand_count got issued=%0d popped=%0d want 1000 1000", issued, popped);
    end
  endtask

  task automatic test_async_reset();
    bit   seen = 1'b0;
    int   stray = 0, lat;
    res_t got, want;
    m_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_in_valid = 1'b1;
      m_in_a = rand_operand(); m_in_b = rand_operand(); m_in_op = 1'(i); m_in_tag = 4'(i + 8);
      tick();
    end
    m_in_valid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = m_out_valid;
      tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rst_fill got out_valid=0 want 1 before reset");
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_async got valid=%b in_ready=%b want 0 1", m_out_valid, m_in_ready);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    m_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_out_valid) stray++;
      tick();
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL rst_stale got %0d stray results want 0", stray);
    end
    run_one_main(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, OP_ADD, 4'd6, got, lat);
    want = ref_model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, OP_ADD, 1'b1, 4'd6);
    total++;
    if (lat !== 6 || got !== want) begin
      bad++;
      $display("FAIL rst_next got lat=%0d %h want lat=6 %h", lat, got, want);
    end
    tick();
  endtask

  initial begin
    m_in_valid = 1'b0; m_in_op = 1'b0; m_in_a = '0; m_in_b = '0; m_in_tag = '0; m_out_ready = 1'b1;
    u_in_valid = 1'b0; u_in_op = 1'b0; u_in_a = '0; u_in_b = '0; u_in_tag = '0; u_out_ready = 1'b1;
    l_in_valid = 1'b0; l_in_op = 1'b0; l_in_a = '0; l_in_b = '0; l_in_tag = '0; l_out_ready = 1'b1;
    test_reset();
    test_signed_ops();
    test_unsigned();
    test_latency1();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
